mmio_uart_tx: RTL and testbench

- Memory-mapped UART transmitter on the processor data-memory port, downstream of the core, in parallel with dmem.
- Snoops the core's store bus (MemWrite, DataAdr, WriteData) and queues bytes written to TX_ADDR in a small FIFO.
- Serialises queued bytes 8N1 onto a single tx line.
- Provides a combinational status word for loads from STAT_ADDR.

---
 rtl/mmio_uart_tx.sv | 171 +++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter that snoops the core's data-memory port.
//   clk        : system clock, rising edge
//   reset      : asynchronous active-low reset
//   MemWrite   : core store strobe
//   DataAdr    : core data address
//   WriteData  : core store data; WriteData[7:0] is queued on stores to TX_ADDR,
//                and WriteData[2] clears overflow on stores to STAT_ADDR
//   StatusData : {25'b0, count[3:0], overflow, full, empty} when DataAdr==STAT_ADDR, else 0
//   tx         : registered serial line, idle high
//   busy       : transmitter active or FIFO holding data
module mmio_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter logic [31:0] TX_ADDR      = 32'h000000F0,
    parameter logic [31:0] STAT_ADDR    = 32'h000000F4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] StatusData,
    output logic        tx,
    output logic        busy
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam int unsigned BW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t         state;
    logic [7:0]     mem [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic           overflow;
    logic [7:0]     shreg;
    logic [2:0]     bit_idx;
    logic [BW-1:0]  baud;

    logic empty;
    logic full;
    logic push_req;
    logic push;
    logic pop;
    logic clr_ovf;
    logic baud_done;
    logic unused_wdata;

    assign empty     = (count == '0);
    assign full      = (count == CW'(FIFO_DEPTH));
    assign push_req  = MemWrite && (DataAdr == TX_ADDR);
    assign push      = push_req && !full;
    assign pop       = (state == IDLE) && !empty;
    assign clr_ovf   = MemWrite && (DataAdr == STAT_ADDR) && WriteData[2];
    assign baud_done = (baud == BW'(CLKS_PER_BIT - 1));
    assign busy      = (state != IDLE) || !empty;

    assign unused_wdata = ^WriteData[31:8];

    always_comb begin
        StatusData = '0;
        if (DataAdr == STAT_ADDR) begin
            StatusData = {25'b0, 4'(count), overflow, full, empty};
        end
    end

    // Storage has no reset; only pointers/count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= WriteData[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // Full is judged on the pre-edge count, so a same-edge pop does not rescue the push.
            // A dropped push outranks a same-edge clear.
            if (push_req && full) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            tx      <= 1'b1;
            shreg   <= '0;
            bit_idx <= '0;
            baud    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (!empty) begin
                        shreg <= mem[rd_ptr];
                        state <= START;
                        tx    <= 1'b0;
                        baud  <= '0;
                    end
                end
                START: begin
                    if (baud_done) begin
                        baud    <= '0;
                        bit_idx <= '0;
                        tx      <= shreg[0];
                        state   <= DATA;
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            // Shift so the next bit is always at shreg[1] ahead of being driven.
                            shreg   <= {1'b0, shreg[7:1]};
                            tx      <= shreg[1];
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                STOP: begin
                    tx <= 1'b1;
                    if (baud_done) begin
                        baud  <= '0;
                        state <= IDLE;
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Testbench for mmio_uart_tx: random and directed stores, a reference model of the
// FIFO/transmitter timeline, and a line monitor that decodes frames against a scoreboard.
module tb_mmio_uart_tx;

    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] TXA   = 32'h000000F0;
    localparam logic [31:0] STA   = 32'h000000F4;

    logic        clk       = 1'b0;
    logic        reset     = 1'b0;
    logic        MemWrite  = 1'b0;
    logic [31:0] DataAdr   = '0;
    logic [31:0] WriteData = '0;
    logic [31:0] StatusData;
    logic        tx;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mmio_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH(DEPTH),
        .TX_ADDR(TXA),
        .STAT_ADDR(STA)
    ) dut (
        .clk(clk),
        .reset(reset),
        .MemWrite(MemWrite),
        .DataAdr(DataAdr),
        .WriteData(WriteData),
        .StatusData(StatusData),
        .tx(tx),
        .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: a queue of pending bytes and the edge at which the current frame ends.
    typedef struct {
        logic [7:0] d;
        int         e;
    } frame_t;

    frame_t     sb[$];
    logic [7:0] mq[$];
    int         ecnt       = 0;
    int         busy_until = -1;
    logic       movf       = 1'b0;
    int         m_pre;
    frame_t     m_f;

    always @(posedge clk) begin
        if (!reset) begin
            mq.delete();
            sb.delete();
            busy_until = -1;
            movf       = 1'b0;
        end else begin
            ecnt++;
            m_pre = mq.size();
            if (MemWrite && DataAdr == TXA && m_pre == DEPTH) movf = 1'b1;
            else if (MemWrite && DataAdr == STA && WriteData[2]) movf = 1'b0;
            if (ecnt > busy_until && m_pre > 0) begin
                m_f.d = mq.pop_front();
                m_f.e = ecnt;
                sb.push_back(m_f);
                busy_until = ecnt + 10 * CPB;
            end
            if (MemWrite && DataAdr == TXA && m_pre < DEPTH) mq.push_back(WriteData[7:0]);
        end
    end

    always @(negedge clk) begin
        if (reset !== 1'b1) chk("busy_in_reset", {31'b0, busy}, 32'd0);
        else chk("busy", {31'b0, busy}, {31'b0, (mq.size() > 0) || (ecnt < busy_until)});
    end

    // Line monitor: decodes each frame and checks it against the scoreboard.
    initial begin : monitor
        frame_t     f;
        logic       have;
        logic       aborted;
        logic [9:0] fr;
        logic [9:0] obs;
        int         bad;
        int         start_e;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && tx === 1'b0) begin
                start_e = ecnt;
                have    = (sb.size() > 0);
                if (have) begin
                    f = sb.pop_front();
                end else begin
                    f.d = '0;
                    f.e = 0;
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame actual=start_at_edge_%0d required=idle", start_e);
                end
                fr      = {1'b1, f.d, 1'b0};
                obs     = '0;
                bad     = 0;
                aborted = 1'b0;
                for (int c = 0; c < 10 * CPB; c++) begin
                    if (c != 0) @(negedge clk);
                    if (reset !== 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (c % CPB == CPB / 2) obs[c / CPB] = tx;
                    if (tx !== fr[c / CPB]) bad++;
                end
                if (have && !aborted) begin
                    chk("frame_start_edge", start_e, f.e);
                    chk("frame_bits", {22'b0, obs}, {22'b0, fr});
                    chk("frame_bad_cycles", bad, 0);
                end
            end
        end
    end

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        MemWrite  = 1'b1;
        DataAdr   = a;
        WriteData = d;
        @(negedge clk);
        MemWrite  = 1'b0;
        DataAdr   = '0;
        WriteData = '0;
    endtask

    task automatic check_status();
        logic [3:0] cnt;
        cnt      = 4'(mq.size());
        MemWrite = 1'b0;
        DataAdr  = STA;
        #1;
        chk("status", StatusData,
            {25'b0, cnt, movf, logic'(mq.size() == DEPTH), logic'(mq.size() == 0)});
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((mq.size() > 0 || ecnt < busy_until) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL wait_idle_timeout actual=%0d required=<3000", n);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin : stim
        int op;
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tx", {31'b0, tx}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        DataAdr = STA;
        #1;
        chk("rst_status", StatusData, 32'h00000001);
        #1 reset = 1'b1;
        @(negedge clk);

        // Single byte, then back-to-back pair
        store(TXA, 32'h55);
        wait_idle();
        store(TXA, 32'hA5);
        store(TXA, 32'h3C);
        wait_idle();

        // Overflow: six stores while idle
        for (int unsigned i = 0; i < 6; i++) store(TXA, 32'h10 + i);
        check_status();
        chk("ovf_status_literal", StatusData, 32'h00000026);
        store(STA, 32'h3);
        check_status();
        chk("ovf_kept", {31'b0, StatusData[2]}, 32'd1);
        store(STA, 32'h4);
        check_status();
        chk("ovf_cleared", {31'b0, StatusData[2]}, 32'd0);
        wait_idle();

        // Address decode
        store(32'hF8, 32'h11);
        store(32'h00, 32'h22);
        store(32'hF1, 32'h33);
        DataAdr = 32'h0;
        #1 chk("stat_other_0", StatusData, 32'd0);
        DataAdr = TXA;
        #1 chk("stat_other_f0", StatusData, 32'd0);
        DataAdr = 32'hF8;
        #1 chk("stat_other_f8", StatusData, 32'd0);
        repeat (20) @(negedge clk);
        chk("decode_tx_idle", {31'b0, tx}, 32'd1);
        check_status();

        // Reset mid-frame with a byte still queued
        store(TXA, 32'h96);
        store(TXA, 32'h69);
        repeat (12) @(negedge clk);
        #2 reset = 1'b0;
        #1 chk("midframe_reset_tx", {31'b0, tx}, 32'd1);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        check_status();
        repeat (60) @(negedge clk);
        chk("after_reset_tx", {31'b0, tx}, 32'd1);

        // Randomised traffic
        for (int i = 0; i < 300; i++) begin
            op = int'($urandom_range(0, 9));
            if (op <= 5) store(TXA, $urandom());
            else if (op == 6) store(STA, $urandom());
            else if (op == 7) begin
                case ($urandom_range(0, 2))
                    0:       store(32'hF8, $urandom());
                    1:       store(32'h00, $urandom());
                    default: store(32'hF1, $urandom());
                endcase
            end else if (op == 8) begin
                check_status();
                @(negedge clk);
            end else begin
                repeat ($urandom_range(0, 60)) @(negedge clk);
            end
        end
        wait_idle();
        chk("scoreboard_drained", sb.size(), 32'd0);
        check_status();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
